// File: rtl/abaud_controller.sv
// -----------------------------------------------------------------------------
// abaud_controller
//
// Auto-baud sequencer for the baud-rate generator path. On request it times a
// 0x55 sync character on the asynchronous receive line. It then derives the
// BRG reload value and the clock-divider tap select, loads both with a
// one-cycle strobe, and raises the receive interrupt flag.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      synchronous reset, active low
//   abaud_req  in   1      level: 1 = run / keep running, 0 = abort / idle
//   uxrx       in   1      asynchronous serial line, idle high
//   clr_if     in   1      one-cycle pulse, clears uxrxif
//   brg_div    out  DIV_W  BRG reload value (registered)
//   clk_sel    out  2      divider tap select k (registered)
//   brg_load   out  1      one-cycle load strobe for brg_div / clk_sel
//   busy       out  1      high in WAIT_START, MEASURE, CALC and LOAD
//   done       out  1      one-cycle pulse on successful completion
//   err        out  1      one-cycle pulse on measurement failure
//   uxrxif     out  1      sticky auto-baud-complete interrupt flag
//
// States
//   S_IDLE       | waiting for abaud_req
//   S_WAIT_START | armed, waiting for the start-bit falling edge
//   S_MEASURE    | counting cycles until the 5th falling edge
//   S_CALC       | derive tap select and reload value from N
//   S_LOAD       | strobe brg_load/done and set uxrxif
// -----------------------------------------------------------------------------
module abaud_controller #(
  parameter int unsigned      CNT_W   = 20,
  parameter int unsigned      DIV_W   = 8,
  parameter logic [DIV_W-1:0] DIV_RST = 8'd53
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abaud_req,
  input  logic             uxrx,
  input  logic             clr_if,
  output logic [DIV_W-1:0] brg_div,
  output logic [1:0]       clk_sel,
  output logic             brg_load,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             uxrxif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_MEASURE,
    S_CALC,
    S_LOAD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   ONE_N   = {{CNT_W{1'b0}}, 1'b1};
  // Largest accepted quotient: N >> (7+k) may equal 2**DIV_W, giving a
  // reload value of all ones.
  localparam logic [CNT_W:0]   DIV_LIM = ONE_N << DIV_W;

  state_t           state_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic             fe;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       edges_q;
  logic [CNT_W:0]   n_q;
  logic [DIV_W-1:0] brg_div_q;
  logic [1:0]       clk_sel_q;
  logic             brg_load_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             uxrxif_q;

  logic             calc_ok_d;
  logic [1:0]       clk_sel_d;
  logic [DIV_W-1:0] brg_div_d;
  logic [CNT_W:0]   quot;

  // Falling edge of the synchronized line.
  assign fe = prev_q & ~sync2_q;

  // Pick the smallest tap whose quotient fits. The loop runs from the top
  // tap down, so the last passing assignment is the smallest k.
  always_comb begin
    calc_ok_d = 1'b0;
    clk_sel_d = 2'd0;
    brg_div_d = '0;
    quot      = '0;
    for (int i = 3; i >= 0; i--) begin
      quot = n_q >> (7 + i);
      if (quot <= DIV_LIM) begin
        calc_ok_d = 1'b1;
        clk_sel_d = 2'(i);
        brg_div_d = DIV_W'(quot - ONE_N);
      end
    end
    // Less than one bit-time per 128 cycles cannot be represented.
    if ((n_q >> 7) == '0) begin
      calc_ok_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      cnt_q      <= '0;
      edges_q    <= '0;
      n_q        <= '0;
      brg_div_q  <= DIV_RST;
      clk_sel_q  <= 2'b01;
      brg_load_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      uxrxif_q   <= 1'b0;
    end else begin
      sync1_q    <= uxrx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      brg_load_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      // A set in the same cycle (CALC branch below) overrides this clear.
      if (clr_if) begin
        uxrxif_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (abaud_req) begin
            state_q <= S_WAIT_START;
            busy_q  <= 1'b1;
          end
        end

        S_WAIT_START: begin
          if (!abaud_req) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (fe) begin
            state_q <= S_MEASURE;
            cnt_q   <= '0;
            edges_q <= 3'd1;
          end
        end

        S_MEASURE: begin
          if (!abaud_req) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (fe && (edges_q == 3'd4)) begin
            n_q     <= {1'b0, cnt_q} + ONE_N;
            state_q <= S_CALC;
          end else if (cnt_q == CNT_MAX) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (fe) begin
              edges_q <= edges_q + 3'd1;
            end
          end
        end

        S_CALC: begin
          if (!abaud_req) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (calc_ok_d) begin
            brg_div_q  <= brg_div_d;
            clk_sel_q  <= clk_sel_d;
            brg_load_q <= 1'b1;
            done_q     <= 1'b1;
            uxrxif_q   <= 1'b1;
            state_q    <= S_LOAD;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        S_LOAD: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign brg_div  = brg_div_q;
  assign clk_sel  = clk_sel_q;
  assign brg_load = brg_load_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign uxrxif   = uxrxif_q;

endmodule

// File: tb/tb_abaud_controller.sv
// -----------------------------------------------------------------------------
// tb_abaud_controller
//
// Drives 0x55 sync characters on uxrx and predicts every output cycle by cycle
// from the character timing the bench itself generated. The divider choice is
// computed by plain integer division.
// -----------------------------------------------------------------------------
module tb_abaud_controller;

  localparam int CNT_W   = 14;
  localparam int DIV_W   = 3;
  localparam int DIV_RST = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             abaud_req;
  logic             uxrx;
  logic             clr_if;
  logic [DIV_W-1:0] brg_div;
  logic [1:0]       clk_sel;
  logic             brg_load;
  logic             busy;
  logic             done;
  logic             err;
  logic             uxrxif;

  abaud_controller #(
    .CNT_W  (CNT_W),
    .DIV_W  (DIV_W),
    .DIV_RST(3'd5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .abaud_req(abaud_req),
    .uxrx     (uxrx),
    .clr_if   (clr_if),
    .brg_div  (brg_div),
    .clk_sel  (clk_sel),
    .brg_load (brg_load),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .uxrxif   (uxrxif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit rst_edge;
  bit chk_en;

  // Expected-event schedule (cycle numbers) and driver schedule.
  int sch_load = -100, sch_err = -100, sch_busy_on = -100, sch_busy_off = -100;
  int sch_clr = -100;
  int new_div, new_sel;
  int drv_clr = -100, drv_drop = -100, drv_rst = -100;

  int exp_div, exp_sel;
  bit exp_if, exp_busy;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst_n;
  end

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
      if (n_fail >= 40) begin
        summary();
        $finish;
      end
    end
  endtask

  // Smallest k with N / 2**(7+k) <= 2**DIV_W; reload is that quotient - 1.
  function automatic void model_calc(input int n, output bit ok, output int k, output int dv);
    ok = 1'b0;
    k  = 0;
    dv = 0;
    if (n / 128 == 0) return;
    for (int kk = 0; kk < 4; kk++) begin
      if (n / (128 << kk) <= (1 << DIV_W)) begin
        ok = 1'b1;
        k  = kk;
        dv = n / (128 << kk) - 1;
        return;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_edge) begin
        exp_div  = DIV_RST;
        exp_sel  = 1;
        exp_if   = 1'b0;
        exp_busy = 1'b0;
      end else begin
        if (cyc == sch_clr)      exp_if = 1'b0;
        if (cyc == sch_load) begin
          exp_div = new_div;
          exp_sel = new_sel;
          exp_if  = 1'b1;
        end
        if (cyc == sch_busy_off) exp_busy = 1'b0;
        if (cyc == sch_busy_on)  exp_busy = 1'b1;
      end
      check("brg_div",  32'(brg_div),  exp_div);
      check("clk_sel",  32'(clk_sel),  exp_sel);
      check("brg_load", 32'(brg_load), 32'(rst_edge && cyc == sch_load));
      check("done",     32'(done),     32'(rst_edge && cyc == sch_load));
      check("err",      32'(err),      32'(rst_edge && cyc == sch_err));
      check("busy",     32'(busy),     32'(exp_busy));
      check("uxrxif",   32'(uxrxif),   32'(exp_if));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    clr_if = (cyc == drv_clr);
    if (cyc == drv_drop) abaud_req = 1'b0;
    if (cyc == drv_rst) begin
      rst_n     = 1'b0;
      abaud_req = 1'b0;
    end
    if (cyc == drv_rst + 3) rst_n = 1'b1;
  endtask

  // One 0x55 character with b cycles per bit. abort_edge / rst_edge_n select
  // the falling edge after which the request is dropped or reset is applied.
  task automatic run_case(input int b, input bit keep, input bit clr_same,
                          input int abort_edge, input int rst_edge_n);
    int j, p1, k, dv, n;
    bit prev, v, dead, ok;
    if (!abaud_req) begin
      abaud_req   = 1'b1;
      sch_busy_on = cyc + 1;
    end
    repeat (8) step();
    prev = 1'b1;
    j    = 0;
    p1   = 0;
    dead = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v    = (i % 2) == 1;
      uxrx = v;
      if (prev && !v) begin
        j++;
        if (j == 1) p1 = cyc;
        if (j == abort_edge) begin
          drv_drop     = cyc + 4;
          sch_busy_off = cyc + 5;
          dead         = 1'b1;
        end
        if (j == rst_edge_n) begin
          drv_rst = cyc + 6;
          dead    = 1'b1;
        end
        if (j == 5 && !dead) begin
          n = cyc - p1;
          model_calc(n, ok, k, dv);
          if (ok) begin
            sch_load     = cyc + 4;
            new_div      = dv;
            new_sel      = k;
            sch_busy_off = cyc + 5;
            if (keep) sch_busy_on = cyc + 6;
          end else begin
            sch_err      = cyc + 4;
            sch_busy_off = cyc + 4;
            if (keep) sch_busy_on = cyc + 5;
          end
          if (!keep) drv_drop = cyc + 4;
          if (clr_same) begin
            drv_clr = cyc + 3;
            sch_clr = cyc + 4;
          end
        end
      end
      prev = v;
      repeat (b) step();
    end
    repeat (6) step();
  endtask

  task automatic clear_if();
    int c;
    c       = cyc;
    drv_clr = c + 1;
    sch_clr = c + 2;
    repeat (3) step();
  endtask

  task automatic run_overflow();
    int p1;
    abaud_req   = 1'b1;
    sch_busy_on = cyc + 1;
    repeat (8) step();
    uxrx         = 1'b0;
    p1           = cyc;
    sch_err      = p1 + CNT_MAX + 4;
    sch_busy_off = sch_err;
    drv_drop     = sch_err;
    repeat (20) step();
    uxrx = 1'b1;
    while (cyc < sch_err + 5) step();
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    summary();
    $finish;
  end

  initial begin
    bit ok;
    int k, dv, b;
    bit keep, cs;

    rst_n     = 1'b0;
    abaud_req = 1'b0;
    uxrx      = 1'b1;
    clr_if    = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();

    model_calc(1000, ok, k, dv);
    check("model_1000_k", k, 0);   check("model_1000_div", dv, 6);
    model_calc(1151, ok, k, dv);
    check("model_1151_div", dv, 7);
    model_calc(1152, ok, k, dv);
    check("model_1152_k", k, 1);   check("model_1152_div", dv, 3);
    model_calc(3000, ok, k, dv);
    check("model_3000_k", k, 2);   check("model_3000_div", dv, 4);
    model_calc(9216, ok, k, dv);
    check("model_9216_ok", 32'(ok), 0);
    model_calc(127, ok, k, dv);
    check("model_127_ok", 32'(ok), 0);

    run_case(125, 1'b1, 1'b0, 0, 0);     // N=1000, request held for restart
    @(negedge clk);
    check("a_brg_div", 32'(brg_div), 6);
    check("a_clk_sel", 32'(clk_sel), 0);
    run_case(375, 1'b0, 1'b1, 0, 0);     // N=3000, clr coincides with set
    @(negedge clk);
    check("b_brg_div", 32'(brg_div), 4);
    check("b_clk_sel", 32'(clk_sel), 2);
    check("b_uxrxif",  32'(uxrxif), 1);
    clear_if();
    @(negedge clk);
    check("clr_uxrxif", 32'(uxrxif), 0);

    run_case(600, 1'b0, 1'b0, 0, 0);     // N=4800 -> k=3
    clear_if();
    run_case(1152, 1'b0, 1'b0, 0, 0);    // N=9216 -> no tap fits
    @(negedge clk);
    check("kerr_brg_div", 32'(brg_div), 3);
    check("kerr_clk_sel", 32'(clk_sel), 3);
    check("kerr_uxrxif",  32'(uxrxif), 0);
    run_case(10, 1'b0, 1'b0, 0, 0);      // N=80 -> too fast

    run_case(150, 1'b0, 1'b0, 3, 0);     // abort after third edge
    run_case(150, 1'b0, 1'b0, 0, 0);     // N=1200 -> k=1
    run_case(100, 1'b0, 1'b0, 0, 2);     // reset mid-measure
    run_case(130, 1'b0, 1'b1, 0, 0);     // N=1040 -> quotient exactly 8
    run_overflow();

    for (int r = 0; r < 8; r++) begin
      b    = $urandom_range(200, 12);
      keep = 1'($urandom_range(1, 0));
      cs   = 1'($urandom_range(1, 0));
      run_case(b, keep, cs, 0, 0);
    end

    abaud_req    = 1'b0;
    sch_busy_off = cyc + 1;
    repeat (4) step();
    @(negedge clk);
    summary();
    $finish;
  end

endmodule
